// File: rtl/lp_csr_sequencer.sv
// Single-entry scheduler for CSR and landing-pad label ops onto the CSR buffer; holds the shadow LPLR.
// Optional commit watchdog enabled by defining LP_SEQ_WATCHDOG_EN.
module lp_csr_sequencer #(
  parameter int unsigned XLEN        = 64,
  parameter logic [11:0] LPLR_ADDR   = 12'h8A0,
  parameter bit          LP_PRIORITY = 1'b0,
  parameter int unsigned WDT_CYCLES  = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              csr_req_valid_i,
  output logic              csr_req_ready_o,
  input  logic [11:0]       csr_req_addr_i,
  input  logic [XLEN-1:0]   csr_req_wdata_i,
  input  logic              lp_req_valid_i,
  output logic              lp_req_ready_o,
  input  logic [1:0]        lp_req_op_i,
  input  logic [8:0]        lp_req_label_i,
  output logic              buf_valid_o,
  input  logic              buf_ready_i,
  output logic [11:0]       buf_addr_o,
  output logic [XLEN-1:0]   buf_wdata_o,
  output logic              buf_src_o,
  input  logic              commit_i,
  output logic [24:0]       lplr_o,
  output logic              lp_mismatch_o,
  output logic              busy_o,
  output logic              wdt_timeout_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_COMMIT} state_e;

  localparam logic [1:0] OP_CLL = 2'd3;

  state_e      state_q;
  logic        rr_last_lp_q;
  logic [1:0]  op_q;
  logic [8:0]  label_q;
  logic        grant_csr, grant_lp, accept;

  function automatic logic [24:0] lp_next(input logic [24:0] lplr, input logic [1:0] op,
                                          input logic [8:0] label);
    logic [24:0] r;
    r = lplr;
    case (op)
      2'd0:    r[8:0]   = label;
      2'd1:    r[16:9]  = label[7:0];
      2'd2:    r[24:17] = label[7:0];
      default: r = lplr;
    endcase
    return r;
  endfunction

  // Arbitration: only in IDLE and never during a flush; one grant at most.
  always_comb begin
    grant_csr = 1'b0;
    grant_lp  = 1'b0;
    if (state_q == IDLE && !flush_i) begin
      if (csr_req_valid_i && lp_req_valid_i) begin
        if (LP_PRIORITY || !rr_last_lp_q) grant_lp = 1'b1;
        else                              grant_csr = 1'b1;
      end else begin
        grant_csr = csr_req_valid_i;
        grant_lp  = lp_req_valid_i;
      end
    end
  end

  assign accept          = grant_csr | grant_lp;
  assign csr_req_ready_o = grant_csr;
  assign lp_req_ready_o  = grant_lp;
  assign busy_o          = (state_q != IDLE);

`ifdef LP_SEQ_WATCHDOG_EN
  localparam int unsigned WDT_W = 16;
  logic [WDT_W-1:0] wdt_cnt_q;
`else
  logic unused_wdt;
  assign unused_wdt    = ^WDT_CYCLES;
  assign wdt_timeout_o = 1'b0;
`endif

  // Op/label sidecar of the holding register; only meaningful while an LP op is held.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q    <= lp_req_op_i;
      label_q <= lp_req_label_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      rr_last_lp_q  <= 1'b1;
      buf_valid_o   <= 1'b0;
      buf_addr_o    <= '0;
      buf_wdata_o   <= '0;
      buf_src_o     <= 1'b0;
      lplr_o        <= '0;
      lp_mismatch_o <= 1'b0;
`ifdef LP_SEQ_WATCHDOG_EN
      wdt_cnt_q     <= '0;
      wdt_timeout_o <= 1'b0;
`endif
    end else begin
      lp_mismatch_o <= 1'b0;
`ifdef LP_SEQ_WATCHDOG_EN
      wdt_timeout_o <= 1'b0;
`endif
      // Commit effect applies even when a flush lands in the same cycle.
      if (state_q == WAIT_COMMIT && commit_i && buf_src_o) begin
        if (op_q == OP_CLL) lp_mismatch_o <= (lplr_o[8:0] != label_q);
        else                lplr_o        <= buf_wdata_o[24:0];
      end
      if (flush_i) begin
        state_q     <= IDLE;
        buf_valid_o <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (accept) begin
            state_q      <= ISSUE;
            buf_valid_o  <= 1'b1;
            buf_src_o    <= grant_lp;
            rr_last_lp_q <= grant_lp;
            if (grant_lp) begin
              buf_addr_o  <= LPLR_ADDR;
              buf_wdata_o <= {{(XLEN-25){1'b0}}, lp_next(lplr_o, lp_req_op_i, lp_req_label_i)};
            end else begin
              buf_addr_o  <= csr_req_addr_i;
              buf_wdata_o <= csr_req_wdata_i;
            end
          end
          ISSUE: if (buf_ready_i) begin
            state_q     <= WAIT_COMMIT;
            buf_valid_o <= 1'b0;
`ifdef LP_SEQ_WATCHDOG_EN
            wdt_cnt_q   <= '0;
`endif
          end
          WAIT_COMMIT: begin
            if (commit_i) state_q <= IDLE;
`ifdef LP_SEQ_WATCHDOG_EN
            else if (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1)) begin
              state_q       <= IDLE;
              wdt_timeout_o <= 1'b1;
            end else begin
              wdt_cnt_q <= wdt_cnt_q + 1'b1;
            end
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lp_csr_sequencer.sv
// Scoreboard bench for lp_csr_sequencer: directed test-plan items plus randomized ops vs a reference model.
module tb_lp_csr_sequencer;
  localparam int XLEN = 64;
  localparam logic [11:0] LPLR_A = 12'h8A0;
`ifdef LP_SEQ_WATCHDOG_EN
  localparam int WDT = 4;
`else
  localparam int WDT = 255;
`endif

  logic clk = 1'b0;
  logic rst_ni, flush_i, csr_req_valid_i, csr_req_ready_o, lp_req_valid_i, lp_req_ready_o;
  logic [11:0] csr_req_addr_i, buf_addr_o;
  logic [XLEN-1:0] csr_req_wdata_i, buf_wdata_o;
  logic [1:0] lp_req_op_i;
  logic [8:0] lp_req_label_i;
  logic buf_valid_o, buf_ready_i, buf_src_o, commit_i, lp_mismatch_o, busy_o, wdt_timeout_o;
  logic [24:0] lplr_o;

  lp_csr_sequencer #(.XLEN(XLEN), .LPLR_ADDR(LPLR_A), .LP_PRIORITY(1'b0), .WDT_CYCLES(WDT)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .csr_req_valid_i(csr_req_valid_i), .csr_req_ready_o(csr_req_ready_o),
    .csr_req_addr_i(csr_req_addr_i), .csr_req_wdata_i(csr_req_wdata_i),
    .lp_req_valid_i(lp_req_valid_i), .lp_req_ready_o(lp_req_ready_o),
    .lp_req_op_i(lp_req_op_i), .lp_req_label_i(lp_req_label_i),
    .buf_valid_o(buf_valid_o), .buf_ready_i(buf_ready_i), .buf_addr_o(buf_addr_o),
    .buf_wdata_o(buf_wdata_o), .buf_src_o(buf_src_o), .commit_i(commit_i),
    .lplr_o(lplr_o), .lp_mismatch_o(lp_mismatch_o), .busy_o(busy_o),
    .wdt_timeout_o(wdt_timeout_o));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0]     addr;
    logic [XLEN-1:0] wdata;
    logic            src;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [24:0] lplr_m = '0;
  bit          rr_last_lp_m = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every buffer handshake must match the oldest expected op.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_ni && buf_valid_o && buf_ready_i) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_handshake", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("buf_addr", buf_addr_o, e.addr);
          chk("buf_wdata", buf_wdata_o, e.wdata);
          chk("buf_src", buf_src_o, e.src);
        end
      end
    end
  end

  always @(posedge clk)
    if (rst_ni && commit_i)
      assert (busy_o && !buf_valid_o) else $error("FAIL commit_outside_wait_commit");

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // fmode: 0 commit, 1 flush in WAIT_COMMIT, 2 flush+commit, 3 flush in ISSUE, 4 watchdog expiry
  task automatic run_op(input bit vc, input bit vl, input logic [11:0] a, input logic [XLEN-1:0] d,
                        input logic [1:0] op, input logic [8:0] lab,
                        input int stall, input int cwait, input int fmode);
    bit          win_lp, exp_mm;
    logic [24:0] nxt;
    exp_t        e;
    @(negedge clk);
    csr_req_valid_i = vc; csr_req_addr_i = a; csr_req_wdata_i = d;
    lp_req_valid_i = vl; lp_req_op_i = op; lp_req_label_i = lab;
    #1;
    win_lp = (vc && vl) ? !rr_last_lp_m : vl;
    chk("both_ready", csr_req_ready_o & lp_req_ready_o, 0);
    chk("grant", {csr_req_ready_o, lp_req_ready_o}, {!win_lp, win_lp});
    rr_last_lp_m = win_lp;
    case (op)
      2'd0:    nxt = (lplr_m & ~25'h1FF) | {16'd0, lab};
      2'd1:    nxt = (lplr_m & ~(25'h0FF << 9)) | ({17'd0, lab[7:0]} << 9);
      2'd2:    nxt = (lplr_m & ~(25'h0FF << 17)) | ({17'd0, lab[7:0]} << 17);
      default: nxt = lplr_m;
    endcase
    e.addr  = win_lp ? LPLR_A : a;
    e.wdata = win_lp ? {39'd0, nxt} : d;
    e.src   = win_lp;
    if (fmode != 3) sb_q.push_back(e);
    @(negedge clk);
    csr_req_valid_i = 1'b0; lp_req_valid_i = 1'b0;
    chk("valid_latency1", buf_valid_o, 1);
    chk("busy_issue", busy_o, 1);
    for (int i = 0; i < stall; i++) begin
      csr_req_valid_i = 1'b1; lp_req_valid_i = 1'b1;
      #1;
      chk("stall_no_accept", {csr_req_ready_o, lp_req_ready_o}, 0);
      chk("stall_valid", buf_valid_o, 1);
      chk("stall_addr", buf_addr_o, e.addr);
      chk("stall_wdata", buf_wdata_o, e.wdata);
      chk("stall_busy", busy_o, 1);
      @(negedge clk);
    end
    csr_req_valid_i = 1'b0; lp_req_valid_i = 1'b0;
    if (fmode == 3) begin
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush_issue_valid", buf_valid_o, 0);
      chk("flush_issue_busy", busy_o, 0);
      chk("flush_issue_lplr", lplr_o, lplr_m);
      return;
    end
    buf_ready_i = 1'b1;
    @(negedge clk);
    buf_ready_i = 1'b0;
    chk("wait_valid_low", buf_valid_o, 0);
    if (fmode == 4) begin
      for (int i = 1; i <= 5; i++) begin
        @(negedge clk);
        chk("wdt_pulse", wdt_timeout_o, (i == 4));
        if (i == 4) chk("wdt_idle", busy_o, 0);
      end
      chk("wdt_lplr", lplr_o, lplr_m);
      return;
    end
    repeat (cwait) @(negedge clk);
    commit_i = (fmode != 1);
    flush_i  = (fmode != 0);
    @(negedge clk);
    commit_i = 1'b0; flush_i = 1'b0;
    exp_mm = 1'b0;
    if (fmode != 1 && win_lp) begin
      if (op == 2'd3) exp_mm = (lplr_m[8:0] != lab);
      else            lplr_m = nxt;
    end
    chk("lplr", lplr_o, lplr_m);
    chk("mismatch", lp_mismatch_o, exp_mm);
    chk("busy_after", busy_o, 0);
    chk("wdt_quiet", wdt_timeout_o, 0);
    @(negedge clk);
    chk("mismatch_one_cycle", lp_mismatch_o, 0);
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; commit_i = 1'b0; buf_ready_i = 1'b0;
    csr_req_valid_i = 1'b0; csr_req_addr_i = '0; csr_req_wdata_i = '0;
    lp_req_valid_i = 1'b0; lp_req_op_i = '0; lp_req_label_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_buf_valid", buf_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_lplr", lplr_o, 0);
    chk("rst_mismatch", lp_mismatch_o, 0);
    chk("rst_wdt", wdt_timeout_o, 0);
    chk("rst_addr_data", {buf_src_o, buf_addr_o, buf_wdata_o[31:0]}, 0);
    rst_ni = 1'b1;

    run_op(0, 1, 12'h000, '0, 2'd0, 9'h1A5, 0, 0, 0);
    chk("tp_sll_lplr", lplr_o, 25'h1A5);
    run_op(1, 1, 12'h300, 64'h0123_4567_89AB_CDEF, 2'd3, 9'h1A5, 0, 0, 0);
    run_op(1, 1, 12'h300, 64'h0123_4567_89AB_CDEF, 2'd3, 9'h1A5, 0, 0, 0);
    run_op(0, 1, 12'h000, '0, 2'd3, 9'h1A4, 0, 0, 0);
    run_op(1, 0, 12'h341, 64'hFEED_0000_BEEF_0001, 2'd0, 9'h000, 3, 1, 0);
    run_op(0, 1, 12'h000, '0, 2'd1, 9'h0FF, 0, 1, 1);
    run_op(0, 1, 12'h000, '0, 2'd1, 9'h0FF, 0, 1, 2);
    chk("tp_sml_flush_commit", lplr_o[16:9], 8'hFF);
    run_op(1, 0, 12'h305, 64'h55, 2'd0, 9'h0, 1, 0, 3);

    @(negedge clk);
    flush_i = 1'b1; csr_req_valid_i = 1'b1; lp_req_valid_i = 1'b1;
    #1;
    chk("flush_idle_no_ready", {csr_req_ready_o, lp_req_ready_o}, 0);
    @(negedge clk);
    flush_i = 1'b0; csr_req_valid_i = 1'b0; lp_req_valid_i = 1'b0;
    chk("flush_idle_busy", busy_o, 0);

`ifdef LP_SEQ_WATCHDOG_EN
    run_op(0, 1, 12'h000, '0, 2'd2, 9'h03C, 0, 0, 4);
`endif

    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(1, 3);
      run_op(r[0], r[1], 12'($urandom), {$urandom, $urandom}, 2'($urandom), 9'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    lp_req_valid_i = 1'b1; lp_req_op_i = 2'd0; lp_req_label_i = 9'h155;
    @(posedge clk);
    #2;
    lp_req_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("amid_rst_busy", busy_o, 0);
    chk("amid_rst_valid", buf_valid_o, 0);
    chk("amid_rst_lplr", lplr_o, 0);
    sb_q.delete();
    lplr_m = '0; rr_last_lp_m = 1'b1;
    @(negedge clk);
    rst_ni = 1'b1;
    run_op(1, 1, 12'h300, 64'h77, 2'd0, 9'h0AA, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
